decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_pkg.sv | 24 ++
 rtl/br_predecode.sv | 15 +
 rtl/decode_queue.sv | 153 +++++++++++++++
 tb/tb_decode_queue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and helpers for the fetch-to-rename decode queue.
// Holds the entry layout and direct-branch predecode definitions.
package decode_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred_taken;
    } fq_entry_t;

    localparam logic [5:0] OP_B  = 6'b010100;
    localparam logic [5:0] OP_BL = 6'b010101;

    // 26-bit word offset split across inst[9:0] (high) and inst[25:10] (low)
    function automatic logic [31:0] br_target(
        input logic [31:0] pc,
        input logic [31:0] inst
    );
        logic [27:0] off;
        off = {inst[9:0], inst[25:10], 2'b00};
        return pc + {{4{off[27]}}, off};
    endfunction

endpackage

// File: rtl/br_predecode.sv
// Combinational direct-branch detector for one queue output slot.
// Flags B/BL and computes the PC-relative target.
module br_predecode
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic        is_br,
    output logic [31:0] target
);

    assign is_br  = (inst[31:26] == OP_B) || (inst[31:26] == OP_BL);
    assign target = br_target(pc, inst);

endmodule

// File: rtl/decode_queue.sv
// Multi-lane instruction queue between fetch and rename, with predecode
// that repairs not-predicted direct branches via BTB renew and redirect.
module decode_queue
    import decode_pkg::*;
#(
    parameter int FETCH_W = 3,
    parameter int DEC_W   = 3,
    parameter int DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [FETCH_W-1:0]           in_valid,
    input  logic [FETCH_W-1:0][31:0]     in_inst,
    input  logic [FETCH_W-1:0][31:0]     in_pc,
    input  logic [FETCH_W-1:0]           in_pred_taken,
    output logic                         in_ready,
    output logic [DEC_W-1:0]             out_valid,
    output logic [DEC_W-1:0][31:0]       out_inst,
    output logic [DEC_W-1:0][31:0]       out_pc,
    output logic [DEC_W-1:0]             out_pred_taken,
    input  logic                         out_ready,
    output logic                         btb_renew_en,
    output logic [31:0]                  btb_renew_pc,
    output logic [31:0]                  btb_renew_target,
    output logic                         redirect_valid,
    output logic [31:0]                  redirect_pc,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fq_entry_t         mem_q [DEPTH];
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              rv_q, rv_d;
    logic [31:0]       rpc_q, rpc_d, rtgt_q, rtgt_d;

    fq_entry_t         slot [DEC_W];
    logic [DEC_W-1:0]  raw_v, is_br;
    logic [31:0]       tgt [DEC_W];

    logic              br_hit, blocked, enq, redirect, we;
    logic [31:0]       hit_pc, hit_tgt;
    logic [CW-1:0]     n_enq, n_deq;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign in_ready = (DEPTH - int'(count)) >= FETCH_W;

    for (genvar g = 0; g < DEC_W; g++) begin : g_slot
        assign slot[g]  = mem_q[rd_ptr_q[AW-1:0] + AW'(g)];
        assign raw_v[g] = count > CW'(g);
        assign out_inst[g]       = slot[g].inst;
        assign out_pc[g]         = slot[g].pc;
        assign out_pred_taken[g] = slot[g].pred_taken;
        br_predecode u_pd (
            .inst   (slot[g].inst),
            .pc     (slot[g].pc),
            .is_br  (is_br[g]),
            .target (tgt[g])
        );
    end

    // Slots younger than an unpredicted direct branch are on the wrong path
    always_comb begin
        out_valid = '0;
        br_hit    = 1'b0;
        blocked   = 1'b0;
        hit_pc    = '0;
        hit_tgt   = '0;
        for (int i = 0; i < DEC_W; i++) begin
            if (raw_v[i] && !blocked) begin
                out_valid[i] = 1'b1;
                if (is_br[i] && !slot[i].pred_taken) begin
                    blocked = 1'b1;
                    br_hit  = 1'b1;
                    hit_pc  = slot[i].pc;
                    hit_tgt = tgt[i];
                end
            end
        end
    end

    always_comb begin
        enq      = in_ready && in_valid[0];
        redirect = out_ready && br_hit;
        we       = enq && !flush && !redirect;
        n_enq    = '0;
        n_deq    = '0;
        for (int i = 0; i < FETCH_W; i++)
            if (enq && in_valid[i]) n_enq = n_enq + CW'(1);
        for (int i = 0; i < DEC_W; i++)
            if (out_ready && out_valid[i]) n_deq = n_deq + CW'(1);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + n_enq;
        rd_ptr_d = rd_ptr_q + n_deq;
        rv_d     = 1'b0;
        rpc_d    = rpc_q;
        rtgt_d   = rtgt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            rv_d     = 1'b1;
            rpc_d    = hit_pc;
            rtgt_d   = hit_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
            rtgt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
            rtgt_q   <= rtgt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (we && in_valid[i]) begin
                mem_q[wr_ptr_q[AW-1:0] + AW'(i)] <= '{
                    inst: in_inst[i],
                    pc: in_pc[i],
                    pred_taken: in_pred_taken[i]
                };
            end
        end
    end

    assign btb_renew_en     = rv_q;
    assign btb_renew_pc     = rpc_q;
    assign btb_renew_target = rtgt_q;
    assign redirect_valid   = rv_q;
    assign redirect_pc      = rtgt_q;

    a_in_valid_contig : assert property (
        @(posedge clk) disable iff (!rst_n)
        (in_valid & (in_valid + FETCH_W'(1))) == '0
    ) else $error("in_valid not contiguous from lane 0");

endmodule

// File: tb/tb_decode_queue.sv
// Scenario bench for decode_queue: fill, wrap, branch repair, flush, reset.
// Enqueued PCs go to a scoreboard queue and are checked on dequeue.
module tb_decode_queue;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [2:0]       in_valid;
    logic [2:0][31:0] in_inst, in_pc;
    logic [2:0]       in_pred_taken;
    logic             in_ready;
    logic [2:0]       out_valid;
    logic [2:0][31:0] out_inst, out_pc;
    logic [2:0]       out_pred_taken;
    logic             out_ready;
    logic             btb_renew_en, redirect_valid;
    logic [31:0]      btb_renew_pc, btb_renew_target, redirect_pc;
    logic [4:0]       count;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    decode_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
        .in_pred_taken(in_pred_taken), .in_ready(in_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_pred_taken(out_pred_taken), .out_ready(out_ready),
        .btb_renew_en(btb_renew_en), .btb_renew_pc(btb_renew_pc),
        .btb_renew_target(btb_renew_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .count(count)
    );

    function automatic logic [31:0] nop_of(input logic [31:0] pc);
        return {6'b000000, pc[27:2]};
    endfunction

    task automatic drive(input int n, input logic [31:0] pc0,
                         input int bslot, input logic [31:0] binst,
                         input logic bpred);
        in_valid      = '0;
        in_pred_taken = '0;
        for (int i = 0; i < 3; i++) begin
            in_pc[i]   = pc0 + 32'(4 * i);
            in_inst[i] = (i == bslot) ? binst : nop_of(pc0 + 32'(4 * i));
            if (i == bslot) in_pred_taken[i] = bpred;
            if (i < n) in_valid[i] = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(0, 32'h0, -1, 32'h0, 1'b0);
        #2;
        tests++;
        if (count !== 5'd0 || in_ready !== 1'b1 || out_valid !== 3'b000) begin
            fails++;
            $display("FAIL reset_state: count=%0d in_ready=%b out_valid=%b want 0/1/000",
                     count, in_ready, out_valid);
        end
        tests++;
        if (redirect_valid !== 1'b0 || btb_renew_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_redirect: redirect=%b renew=%b want 0/0",
                     redirect_valid, btb_renew_en);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_full;
        int exp_cnt = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            tests++;
            if (count !== 5'(exp_cnt)) begin
                fails++;
                $display("FAIL fill_count: got %0d want %0d", count, exp_cnt);
            end
            tests++;
            if (in_ready !== ((16 - exp_cnt) >= 3)) begin
                fails++;
                $display("FAIL fill_in_ready: got %b at count %0d", in_ready, exp_cnt);
            end
            if (exp_cnt + 3 <= 15) begin
                drive(3, 32'h1000_0000 + 32'(4 * exp_cnt), -1, 32'h0, 1'b0);
                exp_cnt += 3;
            end else begin
                drive(3, 32'h2000_0000, -1, 32'h0, 1'b0);
            end
        end
        @(negedge clk);
        drive(0, 32'h0, -1, 32'h0, 1'b0);
        tests++;
        if (count !== 5'd15 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_hold: count=%0d in_ready=%b want 15/0", count, in_ready);
        end
        tests++;
        if (out_valid !== 3'b111 || out_pc[0] !== 32'h1000_0000 || out_pc[2] !== 32'h1000_0008) begin
            fails++;
            $display("FAIL full_head: valid=%b pc0=%h pc2=%h want 111/10000000/10000008",
                     out_valid, out_pc[0], out_pc[2]);
        end
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (count !== 5'd0 || out_valid !== 3'b000 || redirect_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_empty: count=%0d valid=%b redirect=%b want 0/000/0",
                     count, out_valid, redirect_valid);
        end
    endtask

    task automatic test_wrap;
        int sent = 0;
        int got  = 0;
        int n;
        logic [31:0] exp_pc;
        sb.delete();
        for (int c = 0; c < 400 && got < 40; c++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (out_ready) begin
                for (int i = 0; i < 3; i++) begin
                    if (out_valid[i]) begin
                        exp_pc = (sb.size() > 0) ? sb.pop_front() : 32'hdead_beef;
                        got++;
                        tests++;
                        if (out_pc[i] !== exp_pc || out_inst[i] !== nop_of(exp_pc)) begin
                            fails++;
                            $display("FAIL wrap_order: slot %0d pc=%h inst=%h want %h/%h",
                                     i, out_pc[i], out_inst[i], exp_pc, nop_of(exp_pc));
                        end
                    end
                end
            end
            if (in_ready && sent < 40) begin
                n = (40 - sent < 3) ? 40 - sent : 3;
                drive(n, 32'h1c00_0000 + 32'(4 * sent), -1, 32'h0, 1'b0);
                for (int i = 0; i < n; i++) sb.push_back(32'h1c00_0000 + 32'(4 * (sent + i)));
                sent += n;
            end else begin
                drive(0, 32'h0, -1, 32'h0, 1'b0);
            end
        end
        @(negedge clk);
        drive(0, 32'h0, -1, 32'h0, 1'b0);
        out_ready = 1'b0;
        tests++;
        if (got !== 40 || count !== 5'd0) begin
            fails++;
            $display("FAIL wrap_drain: got %0d count %0d want 40/0", got, count);
        end
    endtask

    task automatic branch_case(input string nm, input int bslot,
                               input logic [31:0] binst, input logic bpred,
                               input logic [31:0] base, input logic [2:0] exp_v,
                               input logic [31:0] exp_tgt);
        logic redir;
        redir = !bpred;
        @(negedge clk);
        out_ready = 1'b0;
        drive(3, base, bslot, binst, bpred);
        @(negedge clk);
        drive(0, 32'h0, -1, 32'h0, 1'b0);
        tests++;
        if (out_valid !== exp_v || redirect_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_valid: valid=%b redirect=%b want %b/0",
                     nm, out_valid, redirect_valid, exp_v);
        end
        out_ready = 1'b1;
        if (redir) drive(3, 32'h3000_0000, -1, 32'h0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        drive(0, 32'h0, -1, 32'h0, 1'b0);
        tests++;
        if (redirect_valid !== redir || btb_renew_en !== redir || count !== 5'd0) begin
            fails++;
            $display("FAIL %s_pulse: redirect=%b renew=%b count=%0d want %b/%b/0",
                     nm, redirect_valid, btb_renew_en, count, redir, redir);
        end
        if (redir) begin
            tests++;
            if (redirect_pc !== exp_tgt || btb_renew_target !== exp_tgt ||
                btb_renew_pc !== base + 32'(4 * bslot)) begin
                fails++;
                $display("FAIL %s_target: rpc=%h tgt=%h bpc=%h want %h/%h/%h",
                         nm, redirect_pc, btb_renew_target, btb_renew_pc,
                         exp_tgt, exp_tgt, base + 32'(4 * bslot));
            end
        end
        @(negedge clk);
        tests++;
        if (redirect_valid !== 1'b0 || btb_renew_en !== 1'b0) begin
            fails++;
            $display("FAIL %s_one_shot: redirect=%b renew=%b want 0/0",
                     nm, redirect_valid, btb_renew_en);
        end
    endtask

    task automatic test_unpred_b;
        branch_case("unpred_b", 1, 32'h5000_0400, 1'b0, 32'h1c00_0000, 3'b011, 32'h1c00_0008);
        branch_case("far_b", 1, 32'h5004_0000, 1'b0, 32'h1c00_0000, 3'b011, 32'h1c00_0404);
        branch_case("back_bl", 0, 32'h57ff_ffff, 1'b0, 32'h1c00_0100, 3'b001, 32'h1c00_00fc);
    endtask

    task automatic test_pred_taken;
        branch_case("pred_b", 1, 32'h5000_0400, 1'b1, 32'h1c00_0000, 3'b111, 32'h0);
    endtask

    task automatic test_flush_redirect;
        @(negedge clk);
        drive(3, 32'h1c00_0000, 0, 32'h5000_0400, 1'b0);
        @(negedge clk);
        drive(0, 32'h0, -1, 32'h0, 1'b0);
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (count !== 5'd0 || redirect_valid !== 1'b0 || btb_renew_en !== 1'b0) begin
            fails++;
            $display("FAIL flush_vs_redirect: count=%0d redirect=%b renew=%b want 0/0/0",
                     count, redirect_valid, btb_renew_en);
        end
        @(negedge clk);
        tests++;
        if (redirect_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_vs_redirect_late: redirect=%b want 0", redirect_valid);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(3, 32'h4000_0000 + 32'(12 * i), -1, 32'h0, 1'b0);
        end
        @(negedge clk);
        drive(0, 32'h0, -1, 32'h0, 1'b0);
        tests++;
        if (count !== 5'd9) begin
            fails++;
            $display("FAIL mid_count: got %0d want 9", count);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 3'b000 || count !== 5'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: valid=%b count=%0d in_ready=%b want 000/0/1",
                     out_valid, count, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(2, 32'h5000_0000, -1, 32'h0, 1'b0);
        @(negedge clk);
        drive(0, 32'h0, -1, 32'h0, 1'b0);
        tests++;
        if (count !== 5'd2 || out_valid !== 3'b011 || out_pc[0] !== 32'h5000_0000) begin
            fails++;
            $display("FAIL post_reset_enq: count=%0d valid=%b pc0=%h want 2/011/50000000",
                     count, out_valid, out_pc[0]);
        end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_wrap();
        test_unpred_b();
        test_pred_taken();
        test_flush_redirect();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
